// File: rtl/ocl_axil_regfile.sv
// AXI4-Lite register file: NUM_REGS RW words, one RO synchronised vdip word.
// Define OCL_AXIL_REGFILE_SLVERR_EN to answer unmapped accesses with SLVERR.
module ocl_axil_regfile #(
  parameter int          NUM_REGS  = 8,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0500,
  parameter int          VLED_IDX  = 1
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main,
  input  logic                     s_awvalid,
  input  logic [ADDR_W-1:0]        s_awaddr,
  output logic                     s_awready,
  input  logic                     s_wvalid,
  input  logic [31:0]              s_wdata,
  input  logic [3:0]               s_wstrb,
  output logic                     s_wready,
  output logic                     s_bvalid,
  output logic [1:0]               s_bresp,
  input  logic                     s_bready,
  input  logic                     s_arvalid,
  input  logic [ADDR_W-1:0]        s_araddr,
  output logic                     s_arready,
  output logic                     s_rvalid,
  output logic [31:0]              s_rdata,
  output logic [1:0]               s_rresp,
  input  logic                     s_rready,
  input  logic [15:0]              vdip_in,
  output logic [15:0]              vled_out,
  output logic [32*NUM_REGS-1:0]   regs_q,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] NREG = ADDR_W'(NUM_REGS);

  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rf_q [NUM_REGS];
  logic [31:0]       rf_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [15:0]       vdip_s1_q, vdip_s2_q;

  logic              commit;
  logic              ar_acc;
  logic [ADDR_W-1:0] aw_word, r_word;
  logic              aw_reg, r_reg, r_vdip;
  logic [IDX_W-1:0]  aw_idx, r_idx;
  logic              w_err;
  logic [31:0]       rd_val;
  logic [1:0]        rd_resp;

  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return (a - BASE) >> 2;
  endfunction

  always_comb begin
    aw_word = word_of(aw_addr_q);
    aw_reg  = (aw_addr_q >= BASE) && (aw_word < NREG);
    aw_idx  = aw_word[IDX_W-1:0];
    r_word  = word_of(s_araddr);
    r_reg   = (s_araddr >= BASE) && (r_word < NREG);
    r_vdip  = (s_araddr >= BASE) && (r_word == NREG);
    r_idx   = r_word[IDX_W-1:0];
`ifdef OCL_AXIL_REGFILE_SLVERR_EN
    w_err   = !aw_reg;
`else
    w_err   = 1'b0;
`endif
  end

  always_comb begin
    rd_val  = 32'h0;
    rd_resp = 2'b00;
    if (r_reg) begin
      rd_val = rf_q[r_idx];
    end else if (r_vdip) begin
      rd_val = {16'h0, vdip_s2_q};
    end else begin
`ifdef OCL_AXIL_REGFILE_SLVERR_EN
      rd_resp = 2'b10;
`else
      rd_val  = 32'hDEAD_BEEF;
`endif
    end
  end

  always_comb begin
    aw_full_d  = aw_full_q;
    aw_addr_d  = aw_addr_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    wr_pulse_d = '0;
    commit     = aw_full_q && w_full_q && !bvalid_q;
    ar_acc     = s_arvalid && !rvalid_q;

    if (s_awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_awaddr;
    end
    if (s_wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = s_wdata;
      w_strb_d = s_wstrb;
    end
    if (bvalid_q && s_bready)
      bvalid_d = 1'b0;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = w_err ? 2'b10 : 2'b00;
    end

    // Discarded writes still respond but touch no register.
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_d[i]       = rf_q[i];
      wr_pulse_d[i] = commit && aw_reg && (aw_idx == IDX_W'(i));
      if (wr_pulse_d[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb_q[b])
            rf_d[i][8*b +: 8] = w_data_q[8*b +: 8];
        end
      end
    end

    if (rvalid_q && s_rready)
      rvalid_d = 1'b0;
    if (ar_acc) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_resp;
    end
  end

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      vdip_s1_q  <= '0;
      vdip_s2_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        rf_q[i] <= '0;
    end else begin
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      vdip_s1_q  <= vdip_in;
      vdip_s2_q  <= vdip_s1_q;
      for (int i = 0; i < NUM_REGS; i++)
        rf_q[i] <= rf_d[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_q[32*g +: 32] = rf_q[g];
  end

  assign s_awready = !aw_full_q;
  assign s_wready  = !w_full_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = !rvalid_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign wr_pulse  = wr_pulse_q;
  assign vled_out  = rf_q[VLED_IDX][15:0];

endmodule
